cdc_frame_scheduler: RTL
========================

# cdc_frame_scheduler

Source-domain scheduler that shares one slow cross-domain bus among `NUM_CH` requesters. It round-robin arbitrates pending update requests and loads the granted word, with its channel tag and a toggling sequence bit, onto registered bus outputs. It then holds that frame stable for at least `HOLD_CYCLES` cycles, so the destination side's multi-stage, smoothing synchronizer on `{bus_seq, bus_tag, bus_data}` always captures a coherent frame.

## Interface
- `DATA_WIDTH`, 8: payload width per channel.
- `NUM_CH`, 4: number of requesters; must be ≥2 and ≤ 2^`CH_BITS`.
- `CH_BITS`, 2: tag width.
- `HOLD_CYCLES`, 16: minimum cycles a frame stays stable; must be ≥2. Integration sizes it to cover destination sync plus smoothing depth, scaled by the clock ratio.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  `NUM_CH`  per-channel level request; held until `ack`.
- `data_in`  in  `NUM_CH*DATA_WIDTH`  channel i payload at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ack`  out  `NUM_CH`  one-cycle pulse on the granted channel.
- `bus_data`  out  `DATA_WIDTH`  current frame payload (registered).
- `bus_tag`  out  `CH_BITS`  current frame channel index (registered).
- `bus_seq`  out  1  toggles once per new frame (registered).
- `busy`  out  1  high while a frame's hold window is running.

## Operation
- Reset values: `bus_data`=0, `bus_tag`=0, `bus_seq`=0, `ack`=0, `busy`=0, state IDLE, hold counter 0, round-robin pointer `last`=`NUM_CH-1`, so channel 0 has first priority.
- Reset has priority over all other activity. Asserting it mid-HOLD aborts the frame and applies the reset values on the next cycle. The destination side is reset together with this block.
- States:
  - IDLE: arbitrate every cycle.
  - HOLD: counter `cnt` decrements by 1 each cycle; arbitrate only when `cnt`==0.
- Arbitration: search `req` starting at `last+1`, wrapping modulo `NUM_CH`; the first set bit wins. Simultaneous requests are resolved only by this order.
- Grant at edge E, for winner g:
  - `bus_data` <= `data_in[g]`, sampled at E.
  - `bus_tag` <= g.
  - `bus_seq` <= ~`bus_seq`.
  - `ack[g]` <= 1; all other `ack` bits <= 0.
  - `last` <= g.
  - `cnt` <= `HOLD_CYCLES-1`; state <= HOLD.
- HOLD with `cnt`==0:
  - any `req` set: grant immediately (back-to-back, no IDLE cycle).
  - no `req` set: state <= IDLE, bus outputs unchanged.
- `ack` is high only in the cycle after the grant edge. A requester drops `req` on the edge following `ack`. Since `HOLD_CYCLES`≥2, the same request is never granted twice.
- `req` withdrawn before grant: no transfer, no `ack`, no bus change.
- `bus_*` outputs never change except at a grant edge or on reset.
- `busy` = (state == HOLD).

## Timing
- Latency from `req` high, sampled at edge E in IDLE, to the new bus value and the `ack` pulse: 1 cycle (valid right after E).
- Each frame is stable for exactly `HOLD_CYCLES` cycles under continuous load, and at least `HOLD_CYCLES` cycles in all cases.
- Peak throughput: one frame per `HOLD_CYCLES` cycles.
- Under continuous all-channel load, every channel gets one grant per `NUM_CH*HOLD_CYCLES` cycles.
- No combinational path from inputs to outputs.

## Test plan
- Single request, default parameters: after reset, `req`=0001 and ch0 data 0xA5.
  - Next cycle: `bus_data`=0xA5, `bus_tag`=0, `bus_seq`=1, `ack`=0001 for 1 cycle.
  - `busy` high for 16 cycles, then IDLE with the bus unchanged.
- Continuous load, `req`=1111 held (re-raised after each ack) -> grants 0,1,2,3,0 exactly 16 cycles apart, `bus_seq` toggling each grant.
- Fairness: last grant ch1, then `req`=0110 arriving together -> ch2 granted first, ch1 granted 16 cycles later.
- Withdrawal: `req[3]` pulsed during ch0's HOLD and dropped before `cnt`==0 -> no ack on ch3; FSM returns to IDLE; bus keeps ch0's frame.
- Back-to-back: `req[3]` rises while `cnt`==0 -> ch3 granted at that edge with no IDLE cycle; frame changes exactly `HOLD_CYCLES` cycles after the previous one.
- Reset mid-HOLD, with `cnt`=7 on a ch2 frame -> next cycle all outputs are 0 and state is IDLE. Then `req`=1001 -> ch0 granted first.

Source files
------------

// File: rtl/cdc_frame_scheduler.sv
// cdc_frame_scheduler: round-robin scheduler holding each frame stable on a shared cross-domain bus
module cdc_frame_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_CH      = 4,
    parameter int CH_BITS     = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]            ack,
    output logic [DATA_WIDTH-1:0]        bus_data,
    output logic [CH_BITS-1:0]           bus_tag,
    output logic                         bus_seq,
    output logic                         busy
);
    localparam int CW = $clog2(HOLD_CYCLES);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [CH_BITS-1:0] last, g;
    logic grant;
    always_comb begin
        g = '0;
        // lowest index wins within each pass; channels above last override the wrapped ones
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[i] && i <= int'(last)) g = CH_BITS'(i);
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[i] && i > int'(last)) g = CH_BITS'(i);
        grant = |req && (state == IDLE || cnt == '0);
        state_n = grant ? HOLD : (cnt == '0 ? IDLE : state);
    end
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            last     <= CH_BITS'(NUM_CH - 1);
            ack      <= '0;
            bus_data <= '0;
            bus_tag  <= '0;
            bus_seq  <= 1'b0;
        end else begin
            cnt <= grant ? CW'(HOLD_CYCLES - 1) : (cnt == '0 ? cnt : cnt - 1'b1);
            ack <= grant ? NUM_CH'(1) << g : '0;
            if (grant) begin
                bus_data <= data_in[g*DATA_WIDTH +: DATA_WIDTH];
                bus_tag  <= g;
                bus_seq  <= ~bus_seq;
                last     <= g;
            end
        end
    end
    assign busy = (state == HOLD);
endmodule
